// File: rtl/midi_gate_ctrl_pkg.sv
// Shared definitions for the MIDI key-gate controller.
//   - MIDI status nibbles and the All-Notes-Off controller number
//   - midi_state_t : running-status parser states
//   - note_evt_t   : decoded event handed from the parser to the note stack
package synth_pkg;

  localparam logic [3:0] NOTE_OFF      = 4'h8;
  localparam logic [3:0] NOTE_ON       = 4'h9;
  localparam logic [3:0] CC            = 4'hB;
  localparam logic [3:0] PROG_CHANGE   = 4'hC;
  localparam logic [3:0] CHAN_PRESSURE = 4'hD;
  localparam logic [6:0] ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    NO_STATUS = 2'd0,
    WAIT_D1   = 2'd1,
    WAIT_D2   = 2'd2
  } midi_state_t;

  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_PUSH   = 2'd1,
    OP_REMOVE = 2'd2,
    OP_CLEAR  = 2'd3
  } note_op_t;

  typedef struct packed {
    note_op_t   op;
    logic [6:0] note;
    logic [6:0] vel;
  } note_evt_t;

  // Program Change and Channel Pressure carry a single data byte.
  function automatic logic one_data_byte(input logic [3:0] kind);
    return (kind == PROG_CHANGE) || (kind == CHAN_PRESSURE);
  endfunction

endpackage

// File: rtl/midi_gate_ctrl_note_stack.sv
// Held-note stack with last-note priority.
// Entry 0 is the oldest held note, entry count-1 is the top (most recent).
// Ports:
//   CLK, RESET  : clock, synchronous active-high reset (stack empty)
//   evt_op      : operation to apply this cycle (at most one per cycle)
//   evt_note    : note number for PUSH / REMOVE
//   top         : note at the top of the stack (0 when empty)
//   empty       : stack holds no notes
//   overflow    : one-cycle strobe after a PUSH evicted the oldest entry
module midi_note_stack
  import synth_pkg::*;
#(
  parameter int STACK_DEPTH = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  note_op_t   evt_op,
  input  logic [6:0] evt_note,
  output logic [6:0] top,
  output logic       empty,
  output logic       overflow
);

  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic [6:0]    arr_q [STACK_DEPTH];
  logic [6:0]    arr_d [STACK_DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          hit;
  logic [CW-1:0] hit_idx;
  logic          evict;
  logic          overflow_q;

  always_comb begin
    arr_d   = arr_q;
    count_d = count_q;
    hit     = 1'b0;
    hit_idx = '0;
    evict   = 1'b0;

    // PUSH and REMOVE both start by taking the note out if it is held,
    // so a re-pressed note moves to the top instead of appearing twice.
    if (evt_op == OP_PUSH || evt_op == OP_REMOVE) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (!hit && (CW'(i) < count_q) && (arr_q[i] == evt_note)) begin
          hit     = 1'b1;
          hit_idx = CW'(i);
        end
      end
      if (hit) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++) begin
          if (CW'(i) >= hit_idx) arr_d[i] = arr_q[i+1];
        end
        count_d = count_q - CW'(1);
      end
    end

    if (evt_op == OP_PUSH) begin
      if (count_d == CW'(STACK_DEPTH)) begin
        // Full: shift everything down one slot, dropping the oldest.
        evict = 1'b1;
        for (int i = 0; i < STACK_DEPTH - 1; i++) arr_d[i] = arr_d[i+1];
        arr_d[STACK_DEPTH-1] = evt_note;
      end else begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (CW'(i) == count_d) arr_d[i] = evt_note;
        end
        count_d = count_d + CW'(1);
      end
    end

    if (evt_op == OP_CLEAR) count_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < STACK_DEPTH; i++) arr_q[i] <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      arr_q      <= arr_d;
      count_q    <= count_d;
      overflow_q <= evict;
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (CW'(i + 1) == count_q) top = arr_q[i];
    end
  end

  assign empty    = (count_q == '0);
  assign overflow = overflow_q;

endmodule

// File: rtl/midi_gate_ctrl.sv
// MIDI key-gate source for one monophonic ADSR voice.
// Parses a running-status MIDI byte stream, keeps a last-note-priority
// held-note stack and drives the envelope gate. A new note while the gate
// is high forces a RETRIG_CYCLES low gap so the envelope restarts Attack.
// Ports:
//   CLK, RESET     : clock, synchronous active-high reset
//   byte_valid     : byte_data valid this cycle (no backpressure)
//   byte_data      : received MIDI byte
//   key_gate       : gate to the ADSR key input
//   note           : note at the stack top; holds the last value once empty
//   velocity       : velocity of the most recent accepted note-on
//   note_on_pulse  : one-cycle strobe when a note-on lands on the stack top
//   stack_overflow : one-cycle strobe when a push evicted the oldest note
// Timing: the final byte of a message is decoded into evt_q on edge k, the
// stack/counter update on edge k+1, outputs are valid after edge k+1.
// Handshake: byte_data is consumed on every edge where byte_valid is high;
// there is no ready, so the parser accepts one byte per cycle unconditionally.
module midi_gate_ctrl
  import synth_pkg::*;
#(
  parameter int CHANNEL       = 0,
  parameter int STACK_DEPTH   = 8,
  parameter int RETRIG_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       key_gate,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       note_on_pulse,
  output logic       stack_overflow
);

  localparam int RW = (RETRIG_CYCLES > 0) ? $clog2(RETRIG_CYCLES + 1) : 1;

  // ---------------- parser ----------------
  midi_state_t parser_state, state_d;
  logic [7:0]  status_q, status_d;
  logic [6:0]  d1_q, d1_d;
  note_evt_t   evt_q, evt_d;
  logic [3:0]  kind;
  logic        chan_ok;

  assign kind    = status_q[7:4];
  assign chan_ok = (status_q[3:0] == 4'(CHANNEL));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      parser_state <= NO_STATUS;
      status_q     <= '0;
      d1_q         <= '0;
      evt_q        <= '{op: OP_NONE, note: '0, vel: '0};
    end else begin
      parser_state <= state_d;
      status_q     <= status_d;
      d1_q         <= d1_d;
      evt_q        <= evt_d;
    end
  end

  always_comb begin
    state_d  = parser_state;
    status_d = status_q;
    d1_d     = d1_q;
    evt_d    = '{op: OP_NONE, note: '0, vel: '0};

    // 0xF8-0xFF realtime bytes fall through untouched, even mid-message.
    if (byte_valid && byte_data < 8'hF8) begin
      if (byte_data >= 8'hF0) begin
        state_d = NO_STATUS;
      end else if (byte_data[7]) begin
        status_d = byte_data;
        state_d  = WAIT_D1;
      end else begin
        case (parser_state)
          WAIT_D1: begin
            // Single-data-byte messages complete here and are ignored.
            if (!one_data_byte(kind)) begin
              d1_d    = byte_data[6:0];
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            state_d = WAIT_D1;
            if (chan_ok) begin
              if (kind == NOTE_ON && byte_data[6:0] != 7'd0)
                evt_d = '{op: OP_PUSH, note: d1_q, vel: byte_data[6:0]};
              else if (kind == NOTE_ON || kind == NOTE_OFF)
                evt_d = '{op: OP_REMOVE, note: d1_q, vel: byte_data[6:0]};
              else if (kind == CC && d1_q == ALL_NOTES_OFF)
                evt_d = '{op: OP_CLEAR, note: d1_q, vel: byte_data[6:0]};
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- stack ----------------
  logic [6:0] stack_top;
  logic       stack_empty;

  midi_note_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
    .CLK      (CLK),
    .RESET    (RESET),
    .evt_op   (evt_q.op),
    .evt_note (evt_q.note),
    .top      (stack_top),
    .empty    (stack_empty),
    .overflow (stack_overflow)
  );

  // ---------------- outputs / retrigger ----------------
  logic [RW-1:0] retrig_q;
  logic [6:0]    last_note_q;
  logic [6:0]    velocity_q;
  logic          pulse_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      retrig_q    <= '0;
      last_note_q <= '0;
      velocity_q  <= '0;
      pulse_q     <= 1'b0;
    end else begin
      pulse_q <= (evt_q.op == OP_PUSH);
      if (evt_q.op == OP_PUSH) velocity_q <= evt_q.vel;
      if (!stack_empty) last_note_q <= stack_top;

      // A push while sounding (or already in a gap) opens/extends the gap.
      // An empty stack clears the counter; an emptied stack can only see
      // its next push at least two cycles later, after this clear.
      if (evt_q.op == OP_PUSH && (key_gate || retrig_q != '0))
        retrig_q <= RW'(RETRIG_CYCLES);
      else if (stack_empty)
        retrig_q <= '0;
      else if (retrig_q != '0)
        retrig_q <= retrig_q - RW'(1);
    end
  end

  assign key_gate      = !stack_empty && (retrig_q == '0);
  assign note          = stack_empty ? last_note_q : stack_top;
  assign velocity      = velocity_q;
  assign note_on_pulse = pulse_q;

endmodule

// File: tb/tb_midi_gate_ctrl.sv
module tb_midi_gate_ctrl;

  localparam int CHANNEL = 0;
  localparam int DEPTH   = 8;
  localparam int RETRIG  = 1;

  localparam int EV_NONE = 0, EV_PUSH = 1, EV_REMOVE = 2, EV_CLEAR = 3;

  logic       CLK;
  logic       RESET;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       key_gate;
  logic [6:0] note;
  logic [6:0] velocity;
  logic       note_on_pulse;
  logic       stack_overflow;

  midi_gate_ctrl #(
    .CHANNEL(CHANNEL), .STACK_DEPTH(DEPTH), .RETRIG_CYCLES(RETRIG)
  ) dut (
    .CLK(CLK), .RESET(RESET), .byte_valid(byte_valid), .byte_data(byte_data),
    .key_gate(key_gate), .note(note), .velocity(velocity),
    .note_on_pulse(note_on_pulse), .stack_overflow(stack_overflow)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Held notes as a queue (front = oldest, back = most recent).
  logic [6:0] held[$];
  logic [6:0] m_last, m_vel;
  int         m_gap;
  bit         m_pulse, m_ovf;
  int         p_state;          // 0: no status, 1: expecting first data, 2: expecting second
  logic [7:0] p_status;
  logic [6:0] p_d1;
  int         pend_op;
  logic [6:0] pend_note, pend_vel;

  task automatic model_reset();
    held.delete();
    m_last = '0; m_vel = '0; m_gap = 0; m_pulse = 0; m_ovf = 0;
    p_state = 0; p_status = '0; p_d1 = '0;
    pend_op = EV_NONE; pend_note = '0; pend_vel = '0;
  endtask

  task automatic drop_note(input logic [6:0] n);
    for (int i = held.size() - 1; i >= 0; i--)
      if (held[i] == n) held.delete(i);
  endtask

  // Advances the model across one rising edge with the given inputs.
  task automatic model_step(input bit rst, input bit v, input logic [7:0] b);
    bit gate_before, reloaded;
    m_pulse = 0; m_ovf = 0;
    if (rst) begin
      model_reset();
      return;
    end
    gate_before = (held.size() > 0) && (m_gap == 0);
    reloaded = 0;
    case (pend_op)
      EV_PUSH: begin
        drop_note(pend_note);
        if (held.size() == DEPTH) begin
          void'(held.pop_front());
          m_ovf = 1;
        end
        held.push_back(pend_note);
        m_vel = pend_vel;
        m_pulse = 1;
        if (gate_before || m_gap > 0) begin
          m_gap = RETRIG;
          reloaded = 1;
        end
      end
      EV_REMOVE: drop_note(pend_note);
      EV_CLEAR:  held.delete();
      default: ;
    endcase
    if (held.size() == 0) m_gap = 0;
    else if (!reloaded && m_gap > 0) m_gap--;
    if (held.size() > 0) m_last = held[$];
    pend_op = EV_NONE;

    if (v && b < 8'hF8) begin
      if (b >= 8'hF0) p_state = 0;
      else if (b[7]) begin
        p_status = b;
        p_state = 1;
      end else if (p_state == 1) begin
        if (p_status[7:4] != 4'hC && p_status[7:4] != 4'hD) begin
          p_d1 = b[6:0];
          p_state = 2;
        end
      end else if (p_state == 2) begin
        p_state = 1;
        if (p_status[3:0] == 4'(CHANNEL)) begin
          pend_note = p_d1;
          pend_vel = b[6:0];
          if (p_status[7:4] == 4'h9 && b[6:0] != 0) pend_op = EV_PUSH;
          else if (p_status[7:4] == 4'h9 || p_status[7:4] == 4'h8) pend_op = EV_REMOVE;
          else if (p_status[7:4] == 4'hB && p_d1 == 7'd123) pend_op = EV_CLEAR;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  bit live = 0;
  int ovf_count = 0;

  task automatic compare_all();
    check_eq("key_gate", {31'd0, key_gate}, {31'd0, (held.size() > 0) && (m_gap == 0)});
    check_eq("note", {25'd0, note}, {25'd0, m_last});
    check_eq("velocity", {25'd0, velocity}, {25'd0, m_vel});
    check_eq("note_on_pulse", {31'd0, note_on_pulse}, {31'd0, m_pulse});
    check_eq("stack_overflow", {31'd0, stack_overflow}, {31'd0, m_ovf});
  endtask

  task automatic drive(input bit v, input logic [7:0] b, input bit rst);
    @(negedge CLK);
    if (live) begin
      compare_all();
      if (stack_overflow) ovf_count++;
    end
    RESET = rst;
    byte_valid = v;
    byte_data = v ? b : 8'h00;
    model_step(rst, v, b);
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a); send(b); send(c);
  endtask

  task automatic clear_all();
    send3(8'hB0, 8'h7B, 8'h00);
    idle(3);
  endtask

  // ---------------- random message generator ----------------
  logic [7:0] last_st = 8'h00;

  task automatic emit(input logic [7:0] b);
    if ($urandom_range(0, 9) == 0) send(8'hF8 | 8'($urandom_range(0, 7)));
    if ($urandom_range(0, 7) == 0) idle(1);
    send(b);
  endtask

  task automatic emit_status(input logic [7:0] st);
    if (st != last_st || $urandom_range(0, 2) != 0) emit(st);
    last_st = st;
  endtask

  task automatic gen_msg();
    int r;
    logic [3:0] ch;
    logic [6:0] n, v;
    r  = $urandom_range(0, 99);
    ch = ($urandom_range(0, 9) == 0) ? 4'd1 : 4'd0;
    n  = 7'(60 + $urandom_range(0, 11));
    v  = 7'($urandom_range(1, 127));
    if (r < 40) begin
      emit_status({4'h9, ch}); emit({1'b0, n}); emit({1'b0, v});
    end else if (r < 52) begin
      emit_status({4'h8, ch}); emit({1'b0, n}); emit(8'h00);
    end else if (r < 62) begin
      emit_status({4'h9, ch}); emit({1'b0, n}); emit(8'h00);
    end else if (r < 66) begin
      emit_status({4'hB, ch}); emit(8'h7B); emit(8'h00);
    end else if (r < 74) begin
      emit_status({4'hB, ch}); emit(8'h07); emit({1'b0, v});
    end else if (r < 80) begin
      emit_status(($urandom_range(0, 1) == 0) ? 8'hC0 : 8'hD0); emit({1'b0, v});
    end else if (r < 86) begin
      emit_status(8'hE0); emit({1'b0, n}); emit({1'b0, v});
    end else if (r < 92) begin
      emit(8'hF0); emit({1'b0, v}); emit(8'hF7);
      last_st = 8'h00;
    end else begin
      emit({1'b0, n});
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    RESET = 1'b1; byte_valid = 1'b0; byte_data = 8'h00;
    model_reset();
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    live = 1;
    idle(1);
    check_eq("rst_gate", {31'd0, key_gate}, 32'd0);
    check_eq("rst_note", {25'd0, note}, 32'd0);
    check_eq("rst_vel", {25'd0, velocity}, 32'd0);

    // Basic note on / off with two-clock latency.
    send3(8'h90, 8'h3C, 8'h64); idle(2);
    check_eq("on_gate", {31'd0, key_gate}, 32'd1);
    check_eq("on_note", {25'd0, note}, 32'h3C);
    check_eq("on_vel", {25'd0, velocity}, 32'h64);
    send3(8'h80, 8'h3C, 8'h00); idle(2);
    check_eq("off_gate", {31'd0, key_gate}, 32'd0);

    // Retrigger gap and legato release back to the held note.
    send3(8'h90, 8'h3C, 8'h64); idle(2);
    send3(8'h90, 8'h40, 8'h50); idle(2);
    check_eq("retrig_gap", {31'd0, key_gate}, 32'd0);
    idle(1);
    check_eq("retrig_gate", {31'd0, key_gate}, 32'd1);
    check_eq("retrig_note", {25'd0, note}, 32'h40);
    send3(8'h80, 8'h40, 8'h00); idle(2);
    check_eq("legato_note", {25'd0, note}, 32'h3C);
    check_eq("legato_gate", {31'd0, key_gate}, 32'd1);
    clear_all();

    // Running status, velocity-0 removes the inner note.
    send3(8'h90, 8'h3C, 8'h64); send(8'h40); send(8'h64); send(8'h3C); send(8'h00); idle(3);
    check_eq("rs_note", {25'd0, note}, 32'h40);
    check_eq("rs_gate", {31'd0, key_gate}, 32'd1);
    clear_all();

    // Realtime bytes inside a message.
    send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64); idle(3);
    check_eq("rt_note", {25'd0, note}, 32'h3C);
    check_eq("rt_gate", {31'd0, key_gate}, 32'd1);
    clear_all();

    // Data byte with no status after reset.
    drive(1'b0, 8'h00, 1'b1);
    send(8'h3C); idle(2);
    check_eq("nostat_gate", {31'd0, key_gate}, 32'd0);
    check_eq("nostat_vel", {25'd0, velocity}, 32'd0);

    // Other channel is ignored.
    send3(8'h90, 8'h3C, 8'h64); idle(2);
    send3(8'h91, 8'h40, 8'h22); idle(3);
    check_eq("chan_note", {25'd0, note}, 32'h3C);
    check_eq("chan_vel", {25'd0, velocity}, 32'h64);
    clear_all();

    // Nine distinct notes into an eight-deep stack, then release all.
    ovf_count = 0;
    send(8'h90);
    for (int i = 0; i < 9; i++) begin
      send(8'(30 + i)); send(8'h64);
    end
    idle(3);
    check_eq("ovf_count", ovf_count, 32'd1);
    send(8'h80);
    for (int i = 8; i >= 1; i--) begin
      send(8'(30 + i)); send(8'h00);
    end
    idle(3);
    check_eq("drain_gate", {31'd0, key_gate}, 32'd0);
    check_eq("drain_note", {25'd0, note}, 32'd31);

    // All Notes Off with three held notes.
    send3(8'h90, 8'h3C, 8'h64); send(8'h40); send(8'h64); send(8'h43); send(8'h64); idle(3);
    check_eq("clr_pre_gate", {31'd0, key_gate}, 32'd1);
    send3(8'hB0, 8'h7B, 8'h00); idle(2);
    check_eq("clr_gate", {31'd0, key_gate}, 32'd0);

    // Reset in the middle of a message.
    send(8'h90);
    drive(1'b0, 8'h00, 1'b1);
    send(8'h3C); send(8'h64); idle(3);
    check_eq("midrst_gate", {31'd0, key_gate}, 32'd0);
    check_eq("midrst_note", {25'd0, note}, 32'd0);
    check_eq("midrst_vel", {25'd0, velocity}, 32'd0);

    // Randomised traffic against the model.
    last_st = 8'h00;
    for (int m = 0; m < 700; m++) begin
      if (m == 350) begin
        drive(1'b0, 8'h00, 1'b1);
        last_st = 8'h00;
      end
      gen_msg();
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
